mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 149 ++++++++++++++
 tb/tb_mem_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage. A two-state FSM issues registered data-memory requests,
// waits for the acknowledge with a timeout, and fills the MEM/WB register.
module mem_stage #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_MEM_ctrl_MemRead,
    input  logic        i_MEM_ctrl_MemWrite,
    input  logic        i_MEM_ctrl_Branch,
    input  logic [31:0] i_MEM_data_ALUOut,
    input  logic [31:0] i_MEM_data_RTData,
    input  logic        i_MEM_data_Zero,
    input  logic        i_MEM_data_Overflow,
    input  logic [31:0] i_MEM_data_PCBranch,
    input  logic        i_WB_ctrl_Mem2Reg,
    input  logic        i_WB_ctrl_RegWrite,
    input  logic [31:0] i_WB_data_RegAddrW,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_stall,
    output logic        o_PCSrc,
    output logic [31:0] o_PCBranch,
    output logic        o_WB_ctrl_Mem2Reg,
    output logic        o_WB_ctrl_RegWrite,
    output logic [31:0] o_WB_data_MemData,
    output logic [31:0] o_WB_data_ALUOut,
    output logic [4:0]  o_WB_data_RegAddrW,
    output logic        o_exc,
    output logic [1:0]  o_exc_code
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYC - 1);
    localparam logic [1:0] EXC_OVF  = 2'b01;
    localparam logic [1:0] EXC_MIS  = 2'b10;
    localparam logic [1:0] EXC_TOUT = 2'b11;

    state_t     state;
    logic [7:0] cnt;

    logic memop;
    logic ovf_exc;
    logic mis_exc;
    logic timeout;

    // Upper address bits of the write-back register number are never used.
    logic unused_regaddr;
    assign unused_regaddr = ^i_WB_data_RegAddrW[31:5];

    assign memop      = i_MEM_ctrl_MemRead | i_MEM_ctrl_MemWrite;
    assign ovf_exc    = i_MEM_data_Overflow & (i_WB_ctrl_RegWrite | memop);
    assign mis_exc    = memop & (i_MEM_data_ALUOut[1:0] != 2'b00);
    assign timeout    = (cnt == LAST_CNT);
    assign o_PCBranch = i_MEM_data_PCBranch;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_stall = 1'b0;
        o_PCSrc = 1'b0;
        if (nrst) begin
            if (state == IDLE) begin
                o_stall = memop & ~ovf_exc & ~mis_exc;
                o_PCSrc = i_MEM_ctrl_Branch & i_MEM_data_Zero;
            end else begin
                o_stall = ~i_dmem_ack & ~timeout;
            end
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state              <= IDLE;
            cnt                <= '0;
            o_dmem_req         <= 1'b0;
            o_dmem_we          <= 1'b0;
            o_dmem_addr        <= '0;
            o_dmem_wdata       <= '0;
            o_WB_ctrl_Mem2Reg  <= 1'b0;
            o_WB_ctrl_RegWrite <= 1'b0;
            o_WB_data_MemData  <= '0;
            o_WB_data_ALUOut   <= '0;
            o_WB_data_RegAddrW <= '0;
            o_exc              <= 1'b0;
            o_exc_code         <= 2'b00;
        end else begin
            // Default is a bubble into MEM/WB and no exception pulse.
            o_WB_ctrl_Mem2Reg  <= 1'b0;
            o_WB_ctrl_RegWrite <= 1'b0;
            o_WB_data_MemData  <= '0;
            o_WB_data_ALUOut   <= '0;
            o_WB_data_RegAddrW <= '0;
            o_exc              <= 1'b0;

            case (state)
                IDLE: begin
                    if (ovf_exc) begin
                        o_exc      <= 1'b1;
                        o_exc_code <= EXC_OVF;
                    end else if (mis_exc) begin
                        o_exc      <= 1'b1;
                        o_exc_code <= EXC_MIS;
                    end else if (memop) begin
                        state        <= ACCESS;
                        cnt          <= '0;
                        o_dmem_req   <= 1'b1;
                        o_dmem_we    <= i_MEM_ctrl_MemWrite;
                        o_dmem_addr  <= i_MEM_data_ALUOut;
                        o_dmem_wdata <= i_MEM_data_RTData;
                    end else begin
                        o_WB_ctrl_Mem2Reg  <= i_WB_ctrl_Mem2Reg;
                        o_WB_ctrl_RegWrite <= i_WB_ctrl_RegWrite;
                        o_WB_data_ALUOut   <= i_MEM_data_ALUOut;
                        o_WB_data_RegAddrW <= i_WB_data_RegAddrW[4:0];
                    end
                end

                ACCESS: begin
                    // Ack is checked first so a completion on the timeout cycle still wins.
                    if (i_dmem_ack) begin
                        state              <= IDLE;
                        o_dmem_req         <= 1'b0;
                        o_WB_ctrl_Mem2Reg  <= i_WB_ctrl_Mem2Reg;
                        o_WB_ctrl_RegWrite <= i_WB_ctrl_RegWrite;
                        o_WB_data_ALUOut   <= i_MEM_data_ALUOut;
                        o_WB_data_RegAddrW <= i_WB_data_RegAddrW[4:0];
                        o_WB_data_MemData  <= o_dmem_we ? 32'h0 : i_dmem_rdata;
                    end else if (timeout) begin
                        state      <= IDLE;
                        o_dmem_req <= 1'b0;
                        o_exc      <= 1'b1;
                        o_exc_code <= EXC_TOUT;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle IDLE vectors from a table plus
// hand-written load/store, timeout and reset sequences.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        nrst;
    logic        mem_read, mem_write, branch, zero, ovf;
    logic [31:0] alu_out, rt_data, pc_branch, reg_addr, rdata;
    logic        mem2reg, reg_write, ack;

    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        stall, pcsrc;
    logic [31:0] pcb_out;
    logic        wb_m2r, wb_rw;
    logic [31:0] wb_mem, wb_alu;
    logic [4:0]  wb_addr;
    logic        exc;
    logic [1:0]  exc_code;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYC(4)) dut (
        .clk                 (clk),
        .nrst                (nrst),
        .i_MEM_ctrl_MemRead  (mem_read),
        .i_MEM_ctrl_MemWrite (mem_write),
        .i_MEM_ctrl_Branch   (branch),
        .i_MEM_data_ALUOut   (alu_out),
        .i_MEM_data_RTData   (rt_data),
        .i_MEM_data_Zero     (zero),
        .i_MEM_data_Overflow (ovf),
        .i_MEM_data_PCBranch (pc_branch),
        .i_WB_ctrl_Mem2Reg   (mem2reg),
        .i_WB_ctrl_RegWrite  (reg_write),
        .i_WB_data_RegAddrW  (reg_addr),
        .o_dmem_req          (dmem_req),
        .o_dmem_we           (dmem_we),
        .o_dmem_addr         (dmem_addr),
        .o_dmem_wdata        (dmem_wdata),
        .i_dmem_ack          (ack),
        .i_dmem_rdata        (rdata),
        .o_stall             (stall),
        .o_PCSrc             (pcsrc),
        .o_PCBranch          (pcb_out),
        .o_WB_ctrl_Mem2Reg   (wb_m2r),
        .o_WB_ctrl_RegWrite  (wb_rw),
        .o_WB_data_MemData   (wb_mem),
        .o_WB_data_ALUOut    (wb_alu),
        .o_WB_data_RegAddrW  (wb_addr),
        .o_exc               (exc),
        .o_exc_code          (exc_code)
    );

    typedef struct {
        logic        mem_read, mem_write, branch, zero, ovf, mem2reg, reg_write;
        logic [31:0] alu_out, pc_branch, reg_addr;
        logic        e_stall, e_pcsrc, e_m2r, e_rw, e_exc;
        logic [31:0] e_alu;
        logic [4:0]  e_addr;
        logic [1:0]  e_code;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop_inputs();
        mem_read = 0; mem_write = 0; branch = 0; zero = 0; ovf = 0;
        mem2reg = 0; reg_write = 0; ack = 0;
        alu_out = 0; rt_data = 0; pc_branch = 0; reg_addr = 0; rdata = 0;
    endtask

    task automatic present_load(input logic [31:0] addr, input logic [31:0] rd);
        nop_inputs();
        mem_read = 1; mem2reg = 1; reg_write = 1; alu_out = addr; reg_addr = rd;
    endtask

    task automatic check_bubble(input string name);
        check({name, "_rw"}, 32'(wb_rw), 32'd0);
        check({name, "_m2r"}, 32'(wb_m2r), 32'd0);
    endtask

    initial begin
        //        rd wr br z  ov m2r rw  alu           pcb       raddr          st pc m2r rw exc  e_alu        e_addr code
        vecs[0] = '{0, 0, 0, 0, 0, 0, 1, 32'h1234,     32'h0,    32'd5,         0, 0, 0, 1, 0, 32'h1234,     5'd5,  2'b00};
        vecs[1] = '{0, 0, 1, 1, 0, 0, 0, 32'h55,       32'h40,   32'd0,         0, 1, 0, 0, 0, 32'h55,       5'd0,  2'b00};
        vecs[2] = '{0, 0, 1, 0, 0, 0, 0, 32'h56,       32'h40,   32'd0,         0, 0, 0, 0, 0, 32'h56,       5'd0,  2'b00};
        vecs[3] = '{0, 1, 0, 0, 0, 0, 0, 32'h103,      32'h0,    32'd0,         0, 0, 0, 0, 1, 32'h0,        5'd0,  2'b10};
        vecs[4] = '{0, 0, 0, 0, 0, 0, 1, 32'hABCD,     32'h0,    32'hFFFF_FFFF, 0, 0, 0, 1, 0, 32'hABCD,     5'd31, 2'b10};
        vecs[5] = '{0, 0, 0, 0, 1, 0, 1, 32'h7FFF,     32'h0,    32'd3,         0, 0, 0, 0, 1, 32'h0,        5'd0,  2'b01};
        vecs[6] = '{1, 0, 0, 0, 1, 1, 1, 32'h102,      32'h0,    32'd6,         0, 0, 0, 0, 1, 32'h0,        5'd0,  2'b01};
        vecs[7] = '{1, 0, 0, 0, 0, 1, 1, 32'h101,      32'h0,    32'd6,         0, 0, 0, 0, 1, 32'h0,        5'd0,  2'b10};
        vecs[8] = '{0, 0, 0, 0, 1, 0, 0, 32'h9,        32'h80,   32'd2,         0, 0, 0, 0, 0, 32'h9,        5'd2,  2'b10};
        vecs[9] = '{0, 0, 0, 0, 0, 1, 1, 32'h20,       32'h0,    32'd4,         0, 0, 1, 1, 0, 32'h20,       5'd4,  2'b10};

        // Reset, with a memop and a taken branch presented to prove stall/PCSrc stay low.
        nop_inputs();
        nrst = 0; mem_read = 1; branch = 1; zero = 1;
        step(); step();
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_pcsrc", 32'(pcsrc), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wb_rw", 32'(wb_rw), 32'd0);
        check("rst_wb_alu", wb_alu, 32'd0);
        check("rst_exc", {30'd0, exc_code}, 32'd0);
        check("rst_exc_pulse", 32'(exc), 32'd0);
        nop_inputs();
        nrst = 1;
        step();

        for (int i = 0; i < 10; i++) begin
            nop_inputs();
            mem_read = vecs[i].mem_read; mem_write = vecs[i].mem_write;
            branch = vecs[i].branch; zero = vecs[i].zero; ovf = vecs[i].ovf;
            mem2reg = vecs[i].mem2reg; reg_write = vecs[i].reg_write;
            alu_out = vecs[i].alu_out; pc_branch = vecs[i].pc_branch; reg_addr = vecs[i].reg_addr;
            #1;
            check($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
            check($sformatf("v%0d_pcsrc", i), 32'(pcsrc), 32'(vecs[i].e_pcsrc));
            check($sformatf("v%0d_pcbranch", i), pcb_out, vecs[i].pc_branch);
            step();
            check($sformatf("v%0d_req", i), 32'(dmem_req), 32'd0);
            check($sformatf("v%0d_wb_m2r", i), 32'(wb_m2r), 32'(vecs[i].e_m2r));
            check($sformatf("v%0d_wb_rw", i), 32'(wb_rw), 32'(vecs[i].e_rw));
            check($sformatf("v%0d_wb_alu", i), wb_alu, vecs[i].e_alu);
            check($sformatf("v%0d_wb_addr", i), 32'(wb_addr), 32'(vecs[i].e_addr));
            check($sformatf("v%0d_wb_mem", i), wb_mem, 32'd0);
            check($sformatf("v%0d_exc", i), 32'(exc), 32'(vecs[i].e_exc));
            check($sformatf("v%0d_code", i), 32'(exc_code), 32'(vecs[i].e_code));
        end

        // Load at 0x100, ack in the second ACCESS cycle.
        present_load(32'h100, 32'd7);
        #1 check("ld_stall0", 32'(stall), 32'd1);
        step();
        check("ld_req1", 32'(dmem_req), 32'd1);
        check("ld_we1", 32'(dmem_we), 32'd0);
        check("ld_addr1", dmem_addr, 32'h100);
        check_bubble("ld_b1");
        check("ld_stall1", 32'(stall), 32'd1);
        branch = 1; zero = 1;
        #1 check("ld_pcsrc_access", 32'(pcsrc), 32'd0);
        branch = 0; zero = 0;
        step();
        check("ld_req2", 32'(dmem_req), 32'd1);
        check_bubble("ld_b2");
        ack = 1; rdata = 32'hDEAD_BEEF;
        #1 check("ld_stall2", 32'(stall), 32'd0);
        step();
        check("ld_req3", 32'(dmem_req), 32'd0);
        check("ld_mem", wb_mem, 32'hDEAD_BEEF);
        check("ld_m2r", 32'(wb_m2r), 32'd1);
        check("ld_rw", 32'(wb_rw), 32'd1);
        check("ld_addr", 32'(wb_addr), 32'd7);
        check("ld_alu", wb_alu, 32'h100);

        // Load with ack in the first ACCESS cycle: captured on the second edge.
        present_load(32'h204, 32'd9);
        step();
        check_bubble("ld1_b1");
        ack = 1; rdata = 32'h1357_9BDF;
        step();
        check("ld1_mem", wb_mem, 32'h1357_9BDF);
        check("ld1_rw", 32'(wb_rw), 32'd1);
        check("ld1_req", 32'(dmem_req), 32'd0);

        // Store with both MemRead and MemWrite set behaves as a write.
        nop_inputs();
        mem_read = 1; mem_write = 1; alu_out = 32'h200; rt_data = 32'hA5A5_5A5A;
        step();
        check("st_req", 32'(dmem_req), 32'd1);
        check("st_we", 32'(dmem_we), 32'd1);
        check("st_wdata", dmem_wdata, 32'hA5A5_5A5A);
        ack = 1; rdata = 32'hFFFF_FFFF;
        step();
        check("st_mem", wb_mem, 32'd0);
        check("st_rw", 32'(wb_rw), 32'd0);

        // Timeout: request held exactly 4 cycles, then abort with code 11.
        present_load(32'h300, 32'd8);
        step();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("to_req%0d", i), 32'(dmem_req), 32'd1);
            check($sformatf("to_addr%0d", i), dmem_addr, 32'h300);
            check($sformatf("to_stall%0d", i), 32'(stall), (i < 3) ? 32'd1 : 32'd0);
            step();
        end
        check("to_req_end", 32'(dmem_req), 32'd0);
        check("to_exc", 32'(exc), 32'd1);
        check("to_code", 32'(exc_code), 32'd3);
        check_bubble("to_b");
        nop_inputs();
        ack = 1; rdata = 32'h1111_1111;
        #1 check("late_ack_stall", 32'(stall), 32'd0);
        step();
        check("late_ack_req", 32'(dmem_req), 32'd0);
        check("late_ack_exc", 32'(exc), 32'd0);
        check("late_ack_mem", wb_mem, 32'd0);

        // Ack on the timeout cycle wins: data captured, no exception.
        present_load(32'h400, 32'd10);
        step(); step(); step(); step();
        ack = 1; rdata = 32'hCAFE_F00D;
        #1 check("race_stall", 32'(stall), 32'd0);
        step();
        check("race_mem", wb_mem, 32'hCAFE_F00D);
        check("race_exc", 32'(exc), 32'd0);
        check("race_code", 32'(exc_code), 32'd3);

        // Reset during the second ACCESS cycle abandons the access.
        present_load(32'h500, 32'd11);
        step(); step();
        check("rs_req_before", 32'(dmem_req), 32'd1);
        nrst = 0;
        #1 check("rs_stall_low", 32'(stall), 32'd0);
        step();
        check("rs_req", 32'(dmem_req), 32'd0);
        check("rs_code", 32'(exc_code), 32'd0);
        check("rs_exc", 32'(exc), 32'd0);
        check_bubble("rs_b");
        nrst = 1;
        nop_inputs();
        ack = 1; rdata = 32'h2222_2222;
        step();
        check("rs_ack_mem", wb_mem, 32'd0);
        check("rs_ack_rw", 32'(wb_rw), 32'd0);
        check("rs_ack_req", 32'(dmem_req), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
